iob_pmem_vga_ctrl: RTL and testbench

IOB_PMEM_VGA_CTRL -- requirements
Module: iob_pmem_vga_ctrl

---
 rtl/iob_pmem_vga_pkg.sv | 40 ++++
 rtl/iob_pmem_vga_ctrl_if.sv | 32 +++
 rtl/iob_pmem_vga_timing.sv | 73 +++++++
 rtl/iob_pmem_vga_ctrl.sv | 124 ++++++++++++
 tb/tb_iob_pmem_vga_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/iob_pmem_vga_pkg.sv
// iob_pmem_vga_pkg: shared VGA timing defaults, derived bounds and commit FSM encoding
// Holds 640x480@60 defaults, helpers deriving totals/sync windows from any timing set,
// and the state/select encodings used by the controller.
package iob_pmem_vga_pkg;
  localparam int PIX_DIV_D  = 4;
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  function automatic int f_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction
  function automatic int f_sync_lo(input int act, input int fp);
    return act + fp;
  endfunction
  function automatic int f_sync_hi(input int act, input int fp, input int sync);
    return act + fp + sync - 1;
  endfunction
  localparam int H_TOTAL_D   = f_total(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);
  localparam int V_TOTAL_D   = f_total(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);
  localparam int HS_LO_D     = f_sync_lo(H_ACTIVE_D, H_FP_D);
  localparam int HS_HI_D     = f_sync_hi(H_ACTIVE_D, H_FP_D, H_SYNC_D);
  localparam int VS_LO_D     = f_sync_lo(V_ACTIVE_D, V_FP_D);
  localparam int VS_HI_D     = f_sync_hi(V_ACTIVE_D, V_FP_D, V_SYNC_D);
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } state_t;
  typedef enum logic [1:0] {
    SEL_BALL = 2'd0,
    SEL_BARL = 2'd1,
    SEL_BARR = 2'd2,
    SEL_NONE = 2'd3
  } sel_t;
endpackage

// File: rtl/iob_pmem_vga_ctrl_if.sv
// iob_pmem_vga_ctrl_if: host/pseudo-memory/display signal bundle of the VGA controller
// slave  : controller side (takes config, object writes, commit, rgb_in; drives display, live words)
// master : host / pseudo-memory / display side
interface iob_pmem_vga_ctrl_if;
  logic        cfg_en;
  logic        obj_wen;
  logic [1:0]  obj_wsel;
  logic [31:0] obj_wdata;
  logic        commit_req;
  logic        commit_busy;
  logic [31:0] ball_loc;
  logic [31:0] barl_loc;
  logic [31:0] barr_loc;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [11:0] rgb_in;
  logic [11:0] vga_rgb;
  logic        vga_hs;
  logic        vga_vs;
  logic [15:0] frame_cnt;
  logic        vblank_irq;
  modport slave (
    input  cfg_en, obj_wen, obj_wsel, obj_wdata, commit_req, rgb_in,
    output commit_busy, ball_loc, barl_loc, barr_loc, pixel_x, pixel_y,
           vga_rgb, vga_hs, vga_vs, frame_cnt, vblank_irq
  );
  modport master (
    output cfg_en, obj_wen, obj_wsel, obj_wdata, commit_req, rgb_in,
    input  commit_busy, ball_loc, barl_loc, barr_loc, pixel_x, pixel_y,
           vga_rgb, vga_hs, vga_vs, frame_cnt, vblank_irq
  );
endinterface

// File: rtl/iob_pmem_vga_timing.sv
// iob_pmem_vga_timing: pixel divider, h/v counters, raw syncs, video_on and vblank_start
// clk, arst_n      : clock, async active-low reset
// i_cfg_en         : run enable; low holds divider and counters at 0
// o_h, o_v         : current counter position
// o_video_on       : inside the visible area (and enabled)
// o_hs_n, o_vs_n   : unregistered active-low syncs
// o_vblank_start   : one-clk strobe on the tick where h=0, v=V_ACTIVE
module iob_pmem_vga_timing
  import iob_pmem_vga_pkg::*;
#(
  parameter int PIX_DIV  = PIX_DIV_D,
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       i_cfg_en,
  output logic [9:0] o_h,
  output logic [9:0] o_v,
  output logic       o_video_on,
  output logic       o_hs_n,
  output logic       o_vs_n,
  output logic       o_vblank_start
);
  localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(PIX_DIV - 1);
  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] HT  = 10'(f_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [9:0] HS0 = 10'(f_sync_lo(H_ACTIVE, H_FP));
  localparam logic [9:0] HS1 = 10'(f_sync_hi(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] VT  = 10'(f_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [9:0] VS0 = 10'(f_sync_lo(V_ACTIVE, V_FP));
  localparam logic [9:0] VS1 = 10'(f_sync_hi(V_ACTIVE, V_FP, V_SYNC));
  logic [DW-1:0] r_div;
  logic [9:0]    r_h;
  logic [9:0]    r_v;
  logic          w_tick;
  logic          w_h_wrap;
  assign w_tick   = i_cfg_en && r_div == DIV_MAX;
  assign w_h_wrap = r_h == HT;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else if (!i_cfg_en) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_h <= w_h_wrap ? '0 : r_h + 1'b1;
        if (w_h_wrap) r_v <= r_v == VT ? '0 : r_v + 1'b1;
      end
    end
  end
  // Gating with i_cfg_en makes outputs idle in the same cycle enable drops,
  // before the counters have been cleared.
  assign o_h            = r_h;
  assign o_v            = r_v;
  assign o_video_on     = i_cfg_en && r_h < HA && r_v < VA;
  assign o_hs_n         = !(i_cfg_en && r_h >= HS0 && r_h <= HS1);
  assign o_vs_n         = !(i_cfg_en && r_v >= VS0 && r_v <= VS1);
  assign o_vblank_start = w_tick && r_h == '0 && r_v == VA;
endmodule

// File: rtl/iob_pmem_vga_ctrl.sv
// iob_pmem_vga_ctrl: VGA timing plus shadowed object registers published at vblank
// clk, arst_n : clock, async active-low reset
// bus (slave) : cfg_en, object shadow writes, commit handshake, live object words,
//               pixel coordinate / rgb_in to the pseudo-memory, registered VGA outputs,
//               frame counter and vblank pulse
module iob_pmem_vga_ctrl
  import iob_pmem_vga_pkg::*;
#(
  parameter int PIX_DIV  = PIX_DIV_D,
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input logic                clk,
  input logic                arst_n,
  iob_pmem_vga_ctrl_if.slave bus
);
  logic [9:0]  w_h;
  logic [9:0]  w_v;
  logic        w_video_on;
  logic        w_hs_n;
  logic        w_vs_n;
  logic        w_vblank_start;
  state_t      r_state;
  logic        r_busy;
  logic [31:0] r_sh [3];
  logic [31:0] r_ball;
  logic [31:0] r_barl;
  logic [31:0] r_barr;
  logic [11:0] r_rgb;
  logic        r_hs;
  logic        r_vs;
  logic        r_irq;
  logic [15:0] r_frame;
  iob_pmem_vga_timing #(
    .PIX_DIV (PIX_DIV),
    .H_ACTIVE(H_ACTIVE),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_ACTIVE(V_ACTIVE),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_timing (
    .clk           (clk),
    .arst_n        (arst_n),
    .i_cfg_en      (bus.cfg_en),
    .o_h           (w_h),
    .o_v           (w_v),
    .o_video_on    (w_video_on),
    .o_hs_n        (w_hs_n),
    .o_vs_n        (w_vs_n),
    .o_vblank_start(w_vblank_start)
  );
  // Display outputs register the same counter snapshot, so colour and syncs align.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rgb   <= '0;
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_irq   <= 1'b0;
      r_frame <= '0;
    end else begin
      r_rgb   <= w_video_on ? bus.rgb_in : '0;
      r_hs    <= w_hs_n;
      r_vs    <= w_vs_n;
      r_irq   <= w_vblank_start;
      r_frame <= r_frame + 16'(w_vblank_start);
    end
  end
  // Shadows accept writes only in IDLE; once a commit is pending they are frozen
  // until APPLY copies all three into the live words together.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_sh    <= '{default: '0};
      r_ball  <= '0;
      r_barl  <= '0;
      r_barr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.obj_wen && bus.obj_wsel != SEL_NONE) r_sh[bus.obj_wsel] <= bus.obj_wdata;
          if (bus.commit_req) begin
            r_state <= ST_PENDING;
            r_busy  <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (w_vblank_start || !bus.cfg_en) r_state <= ST_APPLY;
        end
        ST_APPLY: begin
          r_ball  <= r_sh[SEL_BALL];
          r_barl  <= r_sh[SEL_BARL];
          r_barr  <= r_sh[SEL_BARR];
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.commit_busy = r_busy;
  assign bus.ball_loc    = r_ball;
  assign bus.barl_loc    = r_barl;
  assign bus.barr_loc    = r_barr;
  assign bus.pixel_x     = w_video_on ? w_h : '0;
  assign bus.pixel_y     = w_video_on ? w_v : '0;
  assign bus.vga_rgb     = r_rgb;
  assign bus.vga_hs      = r_hs;
  assign bus.vga_vs      = r_vs;
  assign bus.frame_cnt   = r_frame;
  assign bus.vblank_irq  = r_irq;
endmodule

// File: tb/tb_iob_pmem_vga_ctrl.sv
// tb_iob_pmem_vga_ctrl: directed checks of timing, vblank, commit FSM and reset on a 15x10 frame
module tb_iob_pmem_vga_ctrl;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n;
  int   c_rgb, c_hs, c_vs, c_px7, c_lag, c_irq, irq_at, run, run_max;
  logic prev_px7;
  always #5 clk = ~clk;
  iob_pmem_vga_ctrl_if bus();
  // 15 pixels x 10 lines, 2 clk per pixel: frame = 300 clk, hs low h=10..12, vs low v=7..8
  iob_pmem_vga_ctrl #(
    .PIX_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .bus   (bus.slave)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic wait_irq(output int k);
    k = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (bus.vblank_irq) begin
        k = i;
        break;
      end
    end
  endtask
  task automatic wr(input logic [1:0] sel, input logic [31:0] d, input logic commit);
    bus.obj_wen    = 1'b1;
    bus.obj_wsel   = sel;
    bus.obj_wdata  = d;
    bus.commit_req = commit;
    @(negedge clk);
    bus.obj_wen    = 1'b0;
    bus.commit_req = 1'b0;
  endtask
  initial begin
    bus.cfg_en     = 1'b0;
    bus.obj_wen    = 1'b0;
    bus.obj_wsel   = 2'd0;
    bus.obj_wdata  = '0;
    bus.commit_req = 1'b0;
    bus.rgb_in     = 12'hFFF;
    #12;
    chk("rst_busy", bus.commit_busy, 0);
    chk("rst_ball", bus.ball_loc, 0);
    chk("rst_hs", bus.vga_hs, 1);
    chk("rst_vs", bus.vga_vs, 1);
    chk("rst_rgb", bus.vga_rgb, 0);
    chk("rst_frame", bus.frame_cnt, 0);
    chk("rst_irq", bus.vblank_irq, 0);
    @(negedge clk);
    arst_n = 1'b1;
    tick(3);
    chk("off_hs", bus.vga_hs, 1);
    chk("off_rgb", bus.vga_rgb, 0);
    chk("off_px", bus.pixel_x, 0);
    chk("off_frame", bus.frame_cnt, 0);
    bus.cfg_en = 1'b1;
    wait_irq(n);
    chk("first_irq_lat", n, 182);
    chk("first_frame", bus.frame_cnt, 1);
    chk("vblank_rgb", bus.vga_rgb, 0);
    chk("vblank_py", bus.pixel_y, 0);
    {c_rgb, c_hs, c_vs, c_px7, c_lag, c_irq, irq_at, run, run_max} = '0;
    prev_px7 = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      c_rgb += int'(bus.vga_rgb == 12'hFFF);
      c_hs  += int'(!bus.vga_hs);
      c_vs  += int'(!bus.vga_vs);
      c_px7 += int'(bus.pixel_x == 10'd7);
      c_lag += int'(prev_px7 && bus.vga_rgb == 12'hFFF);
      prev_px7 = bus.pixel_x == 10'd7;
      run = bus.vga_hs ? 0 : run + 1;
      run_max = run > run_max ? run : run_max;
      if (bus.vblank_irq) begin
        c_irq++;
        irq_at = i;
      end
    end
    chk("rgb_active_clks", c_rgb, 96);
    chk("hs_low_clks", c_hs, 60);
    chk("vs_low_clks", c_vs, 60);
    chk("hs_pulse_len", run_max, 6);
    chk("px7_clks", c_px7, 12);
    chk("rgb_lag1", c_lag, 12);
    chk("irq_pulses", c_irq, 1);
    chk("irq_period", irq_at, 300);
    chk("frame_2", bus.frame_cnt, 2);
    tick(20);
    wr(2'd1, 32'h0AB0_1234, 1'b0);
    wr(2'd0, 32'h00F0_C850, 1'b1);
    chk("pend_busy", bus.commit_busy, 1);
    chk("pend_ball", bus.ball_loc, 0);
    wr(2'd1, 32'h1234_5678, 1'b1);
    wait_irq(n);
    chk("commitA_wait", n, 277);
    chk("apply_ball_old", bus.ball_loc, 0);
    chk("apply_busy", bus.commit_busy, 1);
    tick(1);
    chk("commitA_ball", bus.ball_loc, 32'h00F0_C850);
    chk("commitA_busy", bus.commit_busy, 0);
    chk("commitA_barl", bus.barl_loc, 32'h0AB0_1234);
    chk("commitA_barr", bus.barr_loc, 0);
    tick(298);
    bus.obj_wen    = 1'b1;
    bus.obj_wsel   = 2'd2;
    bus.obj_wdata  = 32'h0000_0ABC;
    bus.commit_req = 1'b1;
    @(negedge clk);
    bus.obj_wen    = 1'b0;
    bus.commit_req = 1'b0;
    chk("vbs_align_irq", bus.vblank_irq, 1);
    chk("vbs_busy", bus.commit_busy, 1);
    chk("vbs_barr_hold", bus.barr_loc, 0);
    wait_irq(n);
    chk("commitB_wait", n, 300);
    chk("commitB_barr_old", bus.barr_loc, 0);
    tick(1);
    chk("commitB_barr", bus.barr_loc, 32'h0000_0ABC);
    chk("commitB_ball", bus.ball_loc, 32'h00F0_C850);
    chk("commitB_barl", bus.barl_loc, 32'h0AB0_1234);
    wr(2'd0, 32'h0000_0222, 1'b1);
    chk("cfgoff_pend", bus.commit_busy, 1);
    bus.cfg_en = 1'b0;
    tick(1);
    chk("cfgoff_apply_busy", bus.commit_busy, 1);
    chk("cfgoff_ball_old", bus.ball_loc, 32'h00F0_C850);
    tick(1);
    chk("cfgoff_ball", bus.ball_loc, 32'h0000_0222);
    chk("cfgoff_busy", bus.commit_busy, 0);
    chk("cfgoff_hs1", bus.vga_hs, 1);
    chk("cfgoff_vs1", bus.vga_vs, 1);
    chk("cfgoff_rgb0", bus.vga_rgb, 0);
    bus.cfg_en = 1'b1;
    wr(2'd1, 32'h0000_0333, 1'b1);
    chk("rstp_busy", bus.commit_busy, 1);
    #2 arst_n = 1'b0;
    #1;
    chk("rstp_busy0", bus.commit_busy, 0);
    chk("rstp_ball", bus.ball_loc, 0);
    chk("rstp_barl", bus.barl_loc, 0);
    chk("rstp_barr", bus.barr_loc, 0);
    chk("rstp_frame", bus.frame_cnt, 0);
    chk("rstp_hs", bus.vga_hs, 1);
    chk("rstp_vs", bus.vga_vs, 1);
    @(negedge clk);
    arst_n = 1'b1;
    tick(3);
    chk("post_barl", bus.barl_loc, 0);
    chk("post_busy", bus.commit_busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
